// File: rtl/click_tagger.sv
// click_tagger: multi-channel click time-tagger; stamps {channel,timer} into a FWFT FIFO.
// Optional: define CLICK_DROPCNT_EN to add the saturating drop_cnt output.
module click_tagger #(
    parameter int NCH   = 8,
    parameter int CW    = 3,
    parameter int TW    = 29,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       click,
    input  logic [TW-1:0]        timer,
    input  logic                 clear,
    output logic [CW+TW-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW:0]          level,
    output logic                 ovf
`ifdef CLICK_DROPCNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    logic [NCH-1:0]   s1, s2, s3;
    logic [NCH-1:0]   edge_det, pend, drain, lost;
    logic [TW-1:0]    ts [NCH];
    logic [CW+TW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    sel;
    logic             any_pend, full, pop, wr_en;

    assign edge_det  = s2 & ~s3;
    assign full      = (level == (AW+1)'(DEPTH));
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    always_comb begin
        sel      = '0;
        any_pend = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pend[i] && !any_pend) begin
                sel      = CW'(i);
                any_pend = 1'b1;
            end
        end
        pop   = out_valid & out_ready;
        wr_en = any_pend & (~full | pop);
        drain = '0;
        if (wr_en)
            drain[sel] = 1'b1;
        lost = edge_det & pend & ~drain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            pend   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++)
                ts[i] <= '0;
        end else begin
            s1 <= click;
            s2 <= s1;
            s3 <= s2;
            if (clear) begin
                pend   <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                ovf    <= 1'b0;
            end else begin
                // A new edge on a slot being drained this cycle re-arms it.
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (edge_det[i] && !lost[i]) begin
                        pend[i] <= 1'b1;
                        ts[i]   <= timer;
                    end else if (drain[i]) begin
                        pend[i] <= 1'b0;
                    end
                end
                if (|lost)
                    ovf <= 1'b1;
                if (wr_en)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({wr_en, pop})
                    2'b10:   level <= level + (AW+1)'(1);
                    2'b01:   level <= level - (AW+1)'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear)
            mem[wr_ptr] <= {sel, ts[sel]};
    end

`ifdef CLICK_DROPCNT_EN
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int unsigned i = 0; i < NCH; i++)
            drop_sum = drop_sum + 17'(lost[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (clear)
            drop_cnt <= '0;
        else if (drop_sum[16])
            drop_cnt <= '1;
        else
            drop_cnt <= drop_sum[15:0];
    end
`endif

endmodule
